// File: rtl/rv32_enc_pkg.sv
// RV32I encoder shared definitions: opcodes, request classes, FSM states,
// immediate limits and the field-level request bundle.
package rv32_enc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int SHAMT_MAX = 31;
    localparam int BR_MIN    = -4096;
    localparam int BR_MAX    = 4094;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_I      = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4
    } req_class_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WRITE = 2'd2,
        S_FULL  = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0]  cls;
        logic [2:0]  funct3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } enc_req_t;

    function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/instr_word_encoder_if.sv
// Request and instruction-memory write bundle for the instruction word encoder.
interface instr_word_encoder_if #(parameter int ADDR_W = 10);
    logic              Start;
    logic              Stop;
    logic [ADDR_W-1:0] BaseAddr;
    logic              ReqValid;
    logic              ReqReady;
    logic [2:0]        ReqClass;
    logic [2:0]        Funct3;
    logic              Alt;
    logic [4:0]        Rd;
    logic [4:0]        Rs1;
    logic [4:0]        Rs2;
    logic [31:0]       Imm;
    logic              MemWEn;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemWData;
    logic              MemAck;
    logic              Full;
    logic              IllegalReq;
    logic [ADDR_W-1:0] WordCount;

    modport slave (
        input  Start, Stop, BaseAddr, ReqValid, ReqClass, Funct3, Alt, Rd, Rs1, Rs2, Imm, MemAck,
        output ReqReady, MemWEn, MemAddr, MemWData, Full, IllegalReq, WordCount
    );

    modport master (
        output Start, Stop, BaseAddr, ReqValid, ReqClass, Funct3, Alt, Rd, Rs1, Rs2, Imm, MemAck,
        input  ReqReady, MemWEn, MemAddr, MemWData, Full, IllegalReq, WordCount
    );
endinterface

// File: rtl/instr_word_encoder_pack.sv
// Combinational field-to-word packer for RV32I R/I/LOAD/STORE/BRANCH,
// with a legality flag covering class, funct3, Alt and immediate range.
module instr_word_pack
    import rv32_enc_pkg::*;
(
    input  enc_req_t    req,
    output logic [31:0] word,
    output logic        legal
);
    logic imm12_ok, shamt_ok, br_ok;

    always_comb begin
        word     = '0;
        legal    = 1'b0;
        imm12_ok = in_range(req.imm, IMM12_MIN, IMM12_MAX);
        shamt_ok = in_range(req.imm, 0, SHAMT_MAX);
        br_ok    = in_range(req.imm, BR_MIN, BR_MAX) & ~req.imm[0];
        case (req.cls)
            CLS_R: begin
                word  = {(req.alt ? 7'h20 : 7'h00), req.rs2, req.rs1, req.funct3, req.rd, OP_R};
                legal = ~req.alt | (req.funct3 == 3'd0) | (req.funct3 == 3'd5);
            end
            CLS_I: begin
                // Shifts carry the shamt in imm[4:0] and SRAI's marker in imm[10]
                if (req.funct3 == 3'd1 || req.funct3 == 3'd5) begin
                    word  = {1'b0, req.alt, 5'b0, req.imm[4:0], req.rs1, req.funct3, req.rd, OP_I};
                    legal = shamt_ok & ((req.funct3 == 3'd5) | ~req.alt);
                end else begin
                    word  = {req.imm[11:0], req.rs1, req.funct3, req.rd, OP_I};
                    legal = imm12_ok & ~req.alt;
                end
            end
            CLS_LOAD: begin
                word  = {req.imm[11:0], req.rs1, 3'h2, req.rd, OP_LOAD};
                legal = imm12_ok & (req.funct3 == 3'd2);
            end
            CLS_STORE: begin
                word  = {req.imm[11:5], req.rs2, req.rs1, 3'h2, req.imm[4:0], OP_STORE};
                legal = imm12_ok & (req.funct3 == 3'd2);
            end
            CLS_BRANCH: begin
                word  = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                         req.imm[4:1], req.imm[11], OP_BRANCH};
                legal = br_ok & (req.funct3 != 3'd2) & (req.funct3 != 3'd3);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/instr_word_encoder.sv
// Instruction word encoder: accepts field requests, packs them, and streams the
// words sequentially into instruction memory over a write/ack port.
module instr_word_encoder
    import rv32_enc_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_word_encoder_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH_WORDS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, count_q;
    logic [31:0]       wdata_q;
    logic              stop_pend_q, illegal_q;
    logic              ready, hs, start_go, ack_go, legal;
    logic [31:0]       word;
    enc_req_t          req;

    assign req = '{cls: bus.ReqClass, funct3: bus.Funct3, alt: bus.Alt,
                   rd: bus.Rd, rs1: bus.Rs1, rs2: bus.Rs2, imm: bus.Imm};

    instr_word_pack u_pack (.req(req), .word(word), .legal(legal));

    assign ready    = (state_q == S_RUN) & ~bus.Stop;
    assign hs       = bus.ReqValid & ready;
    assign start_go = bus.Start & ~bus.Stop & ((state_q == S_IDLE) | (state_q == S_FULL));
    assign ack_go   = (state_q == S_WRITE) & bus.MemAck;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_go) state_d = S_RUN;
            S_RUN: begin
                if (bus.Stop)        state_d = S_IDLE;
                else if (hs & legal) state_d = S_WRITE;
            end
            S_WRITE: begin
                // A stop seen during the write is honoured only once the memory acks
                if (bus.MemAck) begin
                    if (stop_pend_q | bus.Stop) state_d = S_IDLE;
                    else if (count_q == LAST_CNT) state_d = S_FULL;
                    else state_d = S_RUN;
                end
            end
            S_FULL: begin
                if (bus.Stop)      state_d = S_IDLE;
                else if (start_go) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            count_q     <= '0;
            wdata_q     <= '0;
            stop_pend_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            illegal_q   <= hs & ~legal;
            stop_pend_q <= (state_q == S_WRITE) & (stop_pend_q | bus.Stop);
            if (hs & legal) wdata_q <= word;
            if (start_go) begin
                addr_q  <= bus.BaseAddr & ~ADDR_W'(3);
                count_q <= '0;
            end else if (ack_go) begin
                addr_q  <= addr_q + ADDR_W'(4);
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign bus.ReqReady   = ready;
    assign bus.MemWEn     = (state_q == S_WRITE);
    assign bus.MemAddr    = addr_q;
    assign bus.MemWData   = wdata_q;
    assign bus.Full       = (state_q == S_FULL);
    assign bus.IllegalReq = illegal_q;
    assign bus.WordCount  = count_q;
endmodule

// File: tb/tb_instr_word_encoder.sv
// Directed + randomized bench for instr_word_encoder with an arithmetic
// reference encoder; DUT built with a 4-word program depth.
module tb_instr_word_encoder;
    import rv32_enc_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    logic [9:0] exp_addr;
    int   exp_cnt;

    instr_word_encoder_if #(.ADDR_W(10)) bus ();

    instr_word_encoder #(.ADDR_W(10), .DEPTH_WORDS(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic enc_req_t mk(input int cls, input int f3, input bit alt,
                                    input int rd, input int rs1, input int rs2, input int imm);
        enc_req_t r;
        r.cls = 3'(cls); r.funct3 = 3'(f3); r.alt = alt;
        r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = 32'(imm);
        return r;
    endfunction

    // Reference encoder: each field is placed at its bit offset arithmetically
    function automatic void model(input enc_req_t r, output bit legal, output logic [31:0] w);
        int si, f3, u;
        logic [31:0] base;
        si = $signed(r.imm);
        f3 = int'(r.funct3);
        base = (32'(r.rs1) << 15) | (32'(r.rd) << 7);
        legal = 1'b0;
        w = '0;
        case (int'(r.cls))
            0: begin
                legal = !r.alt || f3 == 0 || f3 == 5;
                w = (32'(r.alt ? 32 : 0) << 25) | (32'(r.rs2) << 20) | base | (32'(f3) << 12) | 32'h33;
            end
            1: begin
                if (f3 == 1 || f3 == 5) begin
                    legal = si >= 0 && si <= 31 && (f3 == 5 || !r.alt);
                    u = (si & 31) + (r.alt ? 1024 : 0);
                end else begin
                    legal = si >= -2048 && si <= 2047 && !r.alt;
                    u = si & 'hFFF;
                end
                w = (32'(u) << 20) | base | (32'(f3) << 12) | 32'h13;
            end
            2: begin
                legal = f3 == 2 && si >= -2048 && si <= 2047;
                w = (32'(si & 'hFFF) << 20) | base | (32'd2 << 12) | 32'h03;
            end
            3: begin
                legal = f3 == 2 && si >= -2048 && si <= 2047;
                u = si & 'hFFF;
                w = (32'(u / 32) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15) | (32'd2 << 12)
                    | (32'(u % 32) << 7) | 32'h23;
            end
            4: begin
                legal = f3 != 2 && f3 != 3 && si >= -4096 && si <= 4094 && (si % 2 == 0);
                u = si & 'h1FFF;
                w = (32'((u / 4096) % 2) << 31) | (32'((u / 32) % 64) << 25) | (32'(r.rs2) << 20)
                    | (32'(r.rs1) << 15) | (32'(f3) << 12) | (32'((u / 2) % 16) << 8)
                    | (32'((u / 2048) % 2) << 7) | 32'h63;
            end
            default: legal = 1'b0;
        endcase
    endfunction

    task automatic do_start(input logic [9:0] base);
        bus.Start = 1'b1; bus.BaseAddr = base;
        tick();
        bus.Start = 1'b0;
        exp_addr = base & 10'h3FC;
        exp_cnt = 0;
        #1;
        chk("start/ready", 32'(bus.ReqReady), 32'd1);
        chk("start/wcnt", 32'(bus.WordCount), 32'd0);
        chk("start/addr", 32'(bus.MemAddr), 32'(exp_addr));
        chk("start/full", 32'(bus.Full), 32'd0);
    endtask

    task automatic do_stop();
        bus.Stop = 1'b1;
        #1 chk("stop/ready_comb", 32'(bus.ReqReady), 32'd0);
        tick();
        bus.Stop = 1'b0;
        #1 chk("stop/idle", 32'(bus.ReqReady), 32'd0);
    endtask

    task automatic send(input enc_req_t r, input int ackdly, input bit stop_mid,
                        input bit use_k, input logic [31:0] kword, input string tag);
        bit legal;
        logic [31:0] w;
        model(r, legal, w);
        if (use_k) w = kword;
        bus.ReqClass = r.cls; bus.Funct3 = r.funct3; bus.Alt = r.alt;
        bus.Rd = r.rd; bus.Rs1 = r.rs1; bus.Rs2 = r.rs2; bus.Imm = r.imm;
        bus.ReqValid = 1'b1;
        #1 chk({tag, "/ready"}, 32'(bus.ReqReady), 32'd1);
        tick();
        bus.ReqValid = 1'b0;
        bus.Imm = $urandom;
        #1;
        if (legal) begin
            chk({tag, "/wen"}, 32'(bus.MemWEn), 32'd1);
            chk({tag, "/data"}, bus.MemWData, w);
            chk({tag, "/addr"}, 32'(bus.MemAddr), 32'(exp_addr));
            chk({tag, "/illegal"}, 32'(bus.IllegalReq), 32'd0);
            if (stop_mid) begin
                bus.Stop = 1'b1;
                tick();
                bus.Stop = 1'b0;
                #1 chk({tag, "/wen_after_stop"}, 32'(bus.MemWEn), 32'd1);
            end
            for (int i = 0; i < ackdly; i++) begin
                tick();
                #1;
                chk({tag, "/hold_wen"}, 32'(bus.MemWEn), 32'd1);
                chk({tag, "/hold_data"}, bus.MemWData, w);
                chk({tag, "/hold_addr"}, 32'(bus.MemAddr), 32'(exp_addr));
            end
            bus.MemAck = 1'b1;
            tick();
            bus.MemAck = 1'b0;
            exp_addr = exp_addr + 10'd4;
            exp_cnt++;
            #1;
            chk({tag, "/wen_drop"}, 32'(bus.MemWEn), 32'd0);
            chk({tag, "/wcnt"}, 32'(bus.WordCount), 32'(exp_cnt));
            chk({tag, "/next_addr"}, 32'(bus.MemAddr), 32'(exp_addr));
            chk({tag, "/full"}, 32'(bus.Full), 32'(exp_cnt == DEPTH && !stop_mid));
            chk({tag, "/ready_after"}, 32'(bus.ReqReady), 32'(exp_cnt != DEPTH && !stop_mid));
        end else begin
            chk({tag, "/ill_pulse"}, 32'(bus.IllegalReq), 32'd1);
            chk({tag, "/ill_nowen"}, 32'(bus.MemWEn), 32'd0);
            chk({tag, "/ill_wcnt"}, 32'(bus.WordCount), 32'(exp_cnt));
            chk({tag, "/ill_addr"}, 32'(bus.MemAddr), 32'(exp_addr));
            tick();
            #1 chk({tag, "/ill_end"}, 32'(bus.IllegalReq), 32'd0);
            chk({tag, "/ill_run"}, 32'(bus.ReqReady), 32'd1);
        end
        tick();
    endtask

    function automatic int rand_imm();
        int bnd[10] = '{-2048, 2047, 2048, -2049, 31, 32, -4096, 4094, 4095, -4098};
        case ($urandom_range(0, 7))
            0: return int'($urandom_range(0, 32)) - 16;
            1: return bnd[$urandom_range(0, 9)];
            2: return int'($urandom);
            3: return int'($urandom_range(0, 31));
            4: return (int'($urandom_range(0, 4094)) - 2048) & ~1;
            default: return int'($urandom_range(0, 4095)) - 2048;
        endcase
    endfunction

    initial begin
        enc_req_t r;
        rst_n = 1'b1;
        bus.Start = 0; bus.Stop = 0; bus.BaseAddr = '0; bus.ReqValid = 0;
        bus.ReqClass = 0; bus.Funct3 = 0; bus.Alt = 0; bus.Rd = 0; bus.Rs1 = 0; bus.Rs2 = 0;
        bus.Imm = 0; bus.MemAck = 0;
        exp_addr = '0; exp_cnt = 0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst/ready", 32'(bus.ReqReady), 32'd0);
        chk("rst/wen", 32'(bus.MemWEn), 32'd0);
        chk("rst/full", 32'(bus.Full), 32'd0);
        chk("rst/illegal", 32'(bus.IllegalReq), 32'd0);
        chk("rst/addr", 32'(bus.MemAddr), 32'd0);
        chk("rst/data", bus.MemWData, 32'd0);
        chk("rst/wcnt", 32'(bus.WordCount), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        #1 chk("idle/ready", 32'(bus.ReqReady), 32'd0);

        do_start(10'h100);
        send(mk(0, 0, 0, 3, 1, 2, 0), 0, 0, 1, 32'h002081B3, "add");
        send(mk(1, 5, 1, 5, 6, 0, 3), 1, 0, 1, 32'h40335293, "srai");
        send(mk(1, 0, 0, 1, 0, 0, -1), 0, 0, 1, 32'hFFF00093, "addi_m1");

        // Start outside IDLE/FULL is ignored
        bus.Start = 1'b1; bus.BaseAddr = 10'h3F0;
        tick();
        bus.Start = 1'b0;
        #1 chk("start_in_run/wcnt", 32'(bus.WordCount), 32'(exp_cnt));
        chk("start_in_run/addr", 32'(bus.MemAddr), 32'(exp_addr));

        do_stop();
        bus.Start = 1'b1; bus.Stop = 1'b1;
        tick();
        bus.Start = 1'b0; bus.Stop = 1'b0;
        #1 chk("start_stop/idle", 32'(bus.ReqReady), 32'd0);

        do_start(10'h040);
        send(mk(4, 1, 0, 0, 1, 2, -8), 0, 0, 1, 32'hFE209CE3, "bne");
        send(mk(4, 1, 0, 0, 1, 2, 3), 0, 0, 0, 32'h0, "bne_odd");
        send(mk(3, 2, 0, 0, 1, 2, 8), 5, 0, 1, 32'h0020A423, "sw_slow");
        send(mk(1, 0, 0, 1, 2, 0, 2048), 0, 0, 0, 32'h0, "addi_ovf");
        send(mk(1, 1, 1, 1, 2, 0, 4), 0, 0, 0, 32'h0, "slli_alt");
        send(mk(1, 5, 0, 1, 2, 0, 32), 0, 0, 0, 32'h0, "srli_32");
        send(mk(5, 0, 0, 1, 2, 3, 0), 0, 0, 0, 32'h0, "cls5");
        send(mk(2, 0, 0, 1, 2, 0, 4), 0, 0, 0, 32'h0, "lb_ill");
        send(mk(0, 1, 1, 1, 2, 3, 0), 0, 0, 0, 32'h0, "sll_alt");
        send(mk(2, 2, 0, 4, 7, 0, -2048), 2, 0, 0, 32'h0, "lw_min");
        send(mk(4, 0, 0, 0, 3, 4, 4094), 0, 0, 0, 32'h0, "beq_max");
        #1 chk("full/ready", 32'(bus.ReqReady), 32'd0);
        chk("full/flag", 32'(bus.Full), 32'd1);

        do_start(10'h203);
        send(mk(0, 0, 1, 9, 10, 11, 0), 1, 1, 0, 32'h0, "sub_stop");
        tick();
        #1 chk("stop_write/idle", 32'(bus.ReqReady), 32'd0);

        do_start(10'h010);
        bus.ReqClass = 3'd0; bus.Funct3 = 3'd0; bus.Alt = 1'b0; bus.ReqValid = 1'b1;
        tick();
        bus.ReqValid = 1'b0;
        #1 chk("rst_mid/wen_before", 32'(bus.MemWEn), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid/wen", 32'(bus.MemWEn), 32'd0);
        chk("rst_mid/addr", 32'(bus.MemAddr), 32'd0);
        chk("rst_mid/wcnt", 32'(bus.WordCount), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        do_start(10'($urandom));
        for (int n = 0; n < 80; n++) begin
            r.cls = 3'($urandom_range(0, 5));
            r.funct3 = ($urandom_range(0, 3) == 0 || r.cls < 2 || r.cls == 4) ? 3'($urandom) : 3'd2;
            r.alt = ($urandom_range(0, 3) == 0);
            r.rd = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
            r.imm = 32'(rand_imm());
            send(r, int'($urandom_range(0, 3)), 1'b0, 1'b0, 32'h0, "rand");
            if (exp_cnt == DEPTH) do_start(10'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
